// File: rtl/stdcore_ubfifo_pkg.sv
// Shared definitions for the multi-channel unified-block FIFO: mode limits,
// reset mode, reserve base, FSM states and the edge pad calculation.
package stdcore_ubfifo_pkg;

  localparam int PIC_W         = 13;
  localparam int UB_LOG2_MIN   = 2;
  localparam int UB_LOG2_MAX   = 6;
  localparam int UNIT_LOG2_MIN = 2;
  localparam int UNIT_LOG2_MAX = 5;
  localparam int RESERVE_BASE  = 256;
  localparam int PAD_W         = 9;

  localparam logic [2:0] UB_LOG2_RST   = 3'd6;
  localparam logic [2:0] UNIT_LOG2_RST = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // A mode is usable only if both sizes are in range and a unit fits in a block.
  function automatic logic cfg_legal(input logic [2:0] ub_l2, input logic [2:0] unit_l2);
    return (int'(ub_l2) >= UB_LOG2_MIN) && (int'(ub_l2) <= UB_LOG2_MAX) &&
           (int'(unit_l2) >= UNIT_LOG2_MIN) && (int'(unit_l2) <= UNIT_LOG2_MAX) &&
           (unit_l2 <= ub_l2);
  endfunction

  // Units missing from a unified block that is clipped by the picture edge:
  // full block unit count minus the units actually covered by picture samples.
  function automatic logic [PAD_W-1:0] calc_pad(input logic [2:0]       ub_l2,
                                                input logic [2:0]       unit_l2,
                                                input logic [PIC_W-1:0] x1,
                                                input logic [PIC_W-1:0] y1,
                                                input logic [PIC_W-1:0] pic_w,
                                                input logic [PIC_W-1:0] pic_h);
    int ub, u, xb, yb, wi, hi, nw, nh, full, pad;
    ub = 1 << ub_l2;
    u  = 1 << unit_l2;
    xb = int'(x1) & ~(ub - 1);
    yb = int'(y1) & ~(ub - 1);
    wi = int'(pic_w) - xb;
    hi = int'(pic_h) - yb;
    if (wi < 0)  wi = 0;
    if (wi > ub) wi = ub;
    if (hi < 0)  hi = 0;
    if (hi > ub) hi = ub;
    nw   = (wi + u - 1) >> unit_l2;
    nh   = (hi + u - 1) >> unit_l2;
    full = (unit_l2 <= ub_l2) ? (1 << (2 * (int'(ub_l2) - int'(unit_l2)))) : 0;
    pad  = full - nw * nh;
    if (pad < 0) pad = 0;
    return PAD_W'(pad);
  endfunction

endpackage

// File: rtl/stdcore_ubfifo_mc_if.sv
// Producer, consumer and configuration bus of the unified-block FIFO.
interface stdcore_ubfifo_mc_if
  import stdcore_ubfifo_pkg::*;
#(
  parameter int DW  = 8,
  parameter int AW  = 8,
  parameter int NCH = 2,
  parameter int CW  = 1
) ();

  logic                  clr;
  logic                  cfg_vld;
  logic                  cfg_rdy;
  logic [2:0]            cfg_ub_log2;
  logic [2:0]            cfg_unit_log2;
  logic [PIC_W-1:0]      pic_w;
  logic [PIC_W-1:0]      pic_h;

  logic [DW-1:0]         p;
  logic [CW-1:0]         p_ch;
  logic [AW-1:0]         p_waddr;
  logic                  p_we_n;
  logic                  p_done;
  logic [CW-1:0]         p_dch;
  logic [AW:0]           p_nunit;
  logic                  p_ublast;
  logic [PIC_W-1:0]      p_x1;
  logic [PIC_W-1:0]      p_y1;
  logic [NCH*(AW+1)-1:0] p_vc;

  logic [DW-1:0]         c;
  logic [CW-1:0]         c_ch;
  logic [AW-1:0]         c_raddr;
  logic                  c_re_n;
  logic                  c_done;
  logic [CW-1:0]         c_dch;
  logic [AW:0]           c_nunit;
  logic                  c_ublast;
  logic [PIC_W-1:0]      c_x1;
  logic [PIC_W-1:0]      c_y1;
  logic [NCH*(AW+1)-1:0] c_st;

  logic [NCH-1:0]        ovf;
  logic [NCH-1:0]        udf;

  modport master (
    output clr, cfg_vld, cfg_ub_log2, cfg_unit_log2, pic_w, pic_h,
    output p, p_ch, p_waddr, p_we_n, p_done, p_dch, p_nunit, p_ublast, p_x1, p_y1,
    output c_ch, c_raddr, c_re_n, c_done, c_dch, c_nunit, c_ublast, c_x1, c_y1,
    input  cfg_rdy, p_vc, c, c_st, ovf, udf
  );

  modport slave (
    input  clr, cfg_vld, cfg_ub_log2, cfg_unit_log2, pic_w, pic_h,
    input  p, p_ch, p_waddr, p_we_n, p_done, p_dch, p_nunit, p_ublast, p_x1, p_y1,
    input  c_ch, c_raddr, c_re_n, c_done, c_dch, c_nunit, c_ublast, c_x1, c_y1,
    output cfg_rdy, p_vc, c, c_st, ovf, udf
  );

endinterface

// File: rtl/ubfifo_pad.sv
// Combinational pad-unit count for one side (producer or consumer) of the FIFO.
module ubfifo_pad
  import stdcore_ubfifo_pkg::*;
(
  input  logic [2:0]       ub_log2,
  input  logic [2:0]       unit_log2,
  input  logic             ublast,
  input  logic [PIC_W-1:0] x1,
  input  logic [PIC_W-1:0] y1,
  input  logic [PIC_W-1:0] pic_w,
  input  logic [PIC_W-1:0] pic_h,
  output logic [PAD_W-1:0] pad
);

  // Only a block that closes a unified block carries edge padding.
  always_comb begin
    pad = ublast ? calc_pad(ub_log2, unit_log2, x1, y1, pic_w, pic_h) : '0;
  end

endmodule

// File: rtl/stdcore_ubfifo_mc.sv
// Multi-channel unified-block FIFO: shared word memory split into channel
// regions, pad-corrected per-channel unit credits updated through a two-stage
// pipeline, and a handshake that only admits a mode change when idle.
module stdcore_ubfifo_mc
  import stdcore_ubfifo_pkg::*;
#(
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int DEPTH = 256,
  parameter int NCH   = 2,
  parameter int CW    = 1,
  parameter int RS    = 0
) (
  input logic                clk,
  input logic                arst,
  stdcore_ubfifo_mc_if.slave bus
);

  localparam int OW      = AW + 1;
  localparam int RES     = RESERVE_BASE >> RS;
  localparam int CAP_RST = DEPTH >> (2 * int'(UNIT_LOG2_RST));
  localparam int VC_RST  = (CAP_RST > RES) ? (CAP_RST - RES) : 0;

  state_e                state_q, state_d;
  logic [2:0]            ub_log2_q, ub_log2_d;
  logic [2:0]            unit_log2_q, unit_log2_d;
  logic                  cfg_rdy_int;
  logic                  occ_zero;
  logic                  pipe_empty;
  logic                  accept;

  logic [PAD_W-1:0]      p_pad, c_pad;

  logic                  p_s1_vld_q, p_s1_vld_d;
  logic [CW-1:0]         p_s1_ch_q, p_s1_ch_d;
  logic [OW-1:0]         p_s1_nunit_q, p_s1_nunit_d;
  logic [PAD_W-1:0]      p_s1_pad_q, p_s1_pad_d;
  logic                  c_s1_vld_q, c_s1_vld_d;
  logic [CW-1:0]         c_s1_ch_q, c_s1_ch_d;
  logic [OW-1:0]         c_s1_nunit_q, c_s1_nunit_d;
  logic [PAD_W-1:0]      c_s1_pad_q, c_s1_pad_d;

  logic [OW-1:0]         occ_q [NCH];
  logic [OW-1:0]         occ_d [NCH];
  logic [NCH-1:0]        ovf_q, ovf_d;
  logic [NCH-1:0]        udf_q, udf_d;
  logic [NCH*OW-1:0]     p_vc_q, p_vc_d;
  logic [NCH*OW-1:0]     c_st_q, c_st_d;

  logic [DW-1:0]         mem [NCH*DEPTH];
  logic [DW-1:0]         c_q, c_d;

  function automatic int cap_of(input logic [2:0] unit_l2);
    return DEPTH >> (2 * int'(unit_l2));
  endfunction

  function automatic logic [OW-1:0] sat_occ(input int net, input int cap);
    if (net > cap)    return OW'(cap);
    else if (net < 0) return '0;
    else              return OW'(net);
  endfunction

  function automatic logic [OW-1:0] vac_of(input int cap, input logic [OW-1:0] occ);
    int v;
    v = cap - int'(occ) - RES;
    return (v < 0) ? '0 : OW'(v);
  endfunction

  ubfifo_pad u_pad_p (
    .ub_log2   (ub_log2_q),
    .unit_log2 (unit_log2_q),
    .ublast    (bus.p_ublast),
    .x1        (bus.p_x1),
    .y1        (bus.p_y1),
    .pic_w     (bus.pic_w),
    .pic_h     (bus.pic_h),
    .pad       (p_pad)
  );

  ubfifo_pad u_pad_c (
    .ub_log2   (ub_log2_q),
    .unit_log2 (unit_log2_q),
    .ublast    (bus.c_ublast),
    .x1        (bus.c_x1),
    .y1        (bus.c_y1),
    .pic_w     (bus.pic_w),
    .pic_h     (bus.pic_h),
    .pad       (c_pad)
  );

  // Mode handshake: accept a legal mode only when every channel is empty and
  // no credit update is pending, then spend one bubble cycle in DRAIN.
  always_comb begin
    occ_zero = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      if (occ_q[k] != '0) occ_zero = 1'b0;
    end
    pipe_empty  = !p_s1_vld_q && !c_s1_vld_q && !bus.p_done && !bus.c_done;
    cfg_rdy_int = (state_q == ST_RUN) && bus.cfg_vld && occ_zero && pipe_empty &&
                  cfg_legal(bus.cfg_ub_log2, bus.cfg_unit_log2);
    state_d     = state_q;
    ub_log2_d   = ub_log2_q;
    unit_log2_d = unit_log2_q;
    case (state_q)
      ST_IDLE:  state_d = ST_RUN;
      ST_RUN: begin
        if (cfg_rdy_int) begin
          state_d     = ST_DRAIN;
          ub_log2_d   = bus.cfg_ub_log2;
          unit_log2_d = bus.cfg_unit_log2;
        end
      end
      ST_DRAIN: state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
    if (bus.clr) begin
      state_d     = ST_IDLE;
      ub_log2_d   = UB_LOG2_RST;
      unit_log2_d = UNIT_LOG2_RST;
    end
  end

  // Stage 1 capture: done pulses in DRAIN or coinciding with clr are dropped.
  always_comb begin
    accept       = (state_q != ST_DRAIN) && !bus.clr;
    p_s1_vld_d   = bus.p_done && accept;
    p_s1_ch_d    = bus.p_dch;
    p_s1_nunit_d = bus.p_nunit;
    p_s1_pad_d   = p_pad;
    c_s1_vld_d   = bus.c_done && accept;
    c_s1_ch_d    = bus.c_dch;
    c_s1_nunit_d = bus.c_nunit;
    c_s1_pad_d   = c_pad;
  end

  // Stage 2: one net occupancy update per channel with saturation, plus the
  // registered occupancy and vacancy views derived from the next occupancy.
  always_comb begin
    int  net;
    int  cap;
    logic hit;
    net   = 0;
    hit   = 1'b0;
    cap   = cap_of(unit_log2_q);
    ovf_d = ovf_q;
    udf_d = udf_q;
    for (int k = 0; k < NCH; k++) begin
      net = int'(occ_q[k]);
      hit = 1'b0;
      if (p_s1_vld_q && (int'(p_s1_ch_q) == k)) begin
        net = net + int'(p_s1_nunit_q) + int'(p_s1_pad_q);
        hit = 1'b1;
      end
      if (c_s1_vld_q && (int'(c_s1_ch_q) == k)) begin
        net = net - int'(c_s1_nunit_q) - int'(c_s1_pad_q);
        hit = 1'b1;
      end
      occ_d[k] = hit ? sat_occ(net, cap) : occ_q[k];
      if (hit && (net > cap)) ovf_d[k] = 1'b1;
      if (hit && (net < 0))   udf_d[k] = 1'b1;
      if (bus.clr) begin
        occ_d[k] = '0;
        ovf_d[k] = 1'b0;
        udf_d[k] = 1'b0;
      end
      c_st_d[k*OW +: OW] = occ_d[k];
      p_vc_d[k*OW +: OW] = vac_of(cap_of(unit_log2_d), occ_d[k]);
    end
  end

  // Read port: one-cycle latency, holds while not reading.
  always_comb begin
    c_d = c_q;
    if (!bus.c_re_n) c_d = mem[{bus.c_ch, bus.c_raddr}];
    if (bus.clr)     c_d = '0;
  end

  // Word memory: never reset, written on the edge where p_we_n is low.
  always_ff @(posedge clk) begin
    if (!bus.p_we_n && (int'(bus.p_ch) < NCH)) mem[{bus.p_ch, bus.p_waddr}] <= bus.p;
  end

  // Control, credit and output state.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= ST_IDLE;
      ub_log2_q   <= UB_LOG2_RST;
      unit_log2_q <= UNIT_LOG2_RST;
      p_s1_vld_q  <= 1'b0;
      c_s1_vld_q  <= 1'b0;
      for (int k = 0; k < NCH; k++) occ_q[k] <= '0;
      ovf_q       <= '0;
      udf_q       <= '0;
      c_st_q      <= '0;
      p_vc_q      <= {NCH{OW'(VC_RST)}};
      c_q         <= '0;
    end else begin
      state_q     <= state_d;
      ub_log2_q   <= ub_log2_d;
      unit_log2_q <= unit_log2_d;
      p_s1_vld_q  <= p_s1_vld_d;
      c_s1_vld_q  <= c_s1_vld_d;
      for (int k = 0; k < NCH; k++) occ_q[k] <= occ_d[k];
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      c_st_q      <= c_st_d;
      p_vc_q      <= p_vc_d;
      c_q         <= c_d;
    end
  end

  // Stage 1 payload, qualified by the valid flops above.
  always_ff @(posedge clk) begin
    p_s1_ch_q    <= p_s1_ch_d;
    p_s1_nunit_q <= p_s1_nunit_d;
    p_s1_pad_q   <= p_s1_pad_d;
    c_s1_ch_q    <= c_s1_ch_d;
    c_s1_nunit_q <= c_s1_nunit_d;
    c_s1_pad_q   <= c_s1_pad_d;
  end

  assign bus.cfg_rdy = cfg_rdy_int;
  assign bus.p_vc    = p_vc_q;
  assign bus.c_st    = c_st_q;
  assign bus.c       = c_q;
  assign bus.ovf     = ovf_q;
  assign bus.udf     = udf_q;

endmodule

// File: tb/tb_stdcore_ubfifo_mc.sv
// Directed bench for stdcore_ubfifo_mc with DEPTH=4096 (CAP=256 at unit 4)
// and RS=2 (reserve 64).
module tb_stdcore_ubfifo_mc;

  localparam int DW    = 8;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;
  localparam int NCH   = 2;
  localparam int CW    = 1;
  localparam int RS    = 2;
  localparam int OW    = AW + 1;

  logic clk = 1'b0;
  logic arst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  stdcore_ubfifo_mc_if #(.DW(DW), .AW(AW), .NCH(NCH), .CW(CW)) bus ();

  stdcore_ubfifo_mc #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .NCH(NCH), .CW(CW), .RS(RS)
  ) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] st(input int k);
    return bus.c_st[k*OW +: OW];
  endfunction

  function automatic logic [OW-1:0] vc(input int k);
    return bus.p_vc[k*OW +: OW];
  endfunction

  task automatic set_p(input int ch, input int n, input int ub, input int x, input int y);
    bus.p_dch    = CW'(ch);
    bus.p_nunit  = OW'(n);
    bus.p_ublast = 1'(ub);
    bus.p_x1     = 13'(x);
    bus.p_y1     = 13'(y);
    bus.p_done   = 1'b1;
  endtask

  task automatic set_c(input int ch, input int n, input int ub, input int x, input int y);
    bus.c_dch    = CW'(ch);
    bus.c_nunit  = OW'(n);
    bus.c_ublast = 1'(ub);
    bus.c_x1     = 13'(x);
    bus.c_y1     = 13'(y);
    bus.c_done   = 1'b1;
  endtask

  task automatic pulse_p(input int ch, input int n, input int ub, input int x, input int y);
    set_p(ch, n, ub, x, y);
    tick();
    bus.p_done = 1'b0;
  endtask

  task automatic pulse_c(input int ch, input int n, input int ub, input int x, input int y);
    set_c(ch, n, ub, x, y);
    tick();
    bus.c_done = 1'b0;
  endtask

  initial begin
    arst              = 1'b1;
    bus.clr           = 1'b0;
    bus.cfg_vld       = 1'b0;
    bus.cfg_ub_log2   = 3'd6;
    bus.cfg_unit_log2 = 3'd2;
    bus.pic_w         = 13'd1920;
    bus.pic_h         = 13'd1080;
    bus.p             = '0;
    bus.p_ch          = '0;
    bus.p_waddr       = '0;
    bus.p_we_n        = 1'b1;
    bus.p_done        = 1'b0;
    bus.p_dch         = '0;
    bus.p_nunit       = '0;
    bus.p_ublast      = 1'b0;
    bus.p_x1          = '0;
    bus.p_y1          = '0;
    bus.c_ch          = '0;
    bus.c_raddr       = '0;
    bus.c_re_n        = 1'b1;
    bus.c_done        = 1'b0;
    bus.c_dch         = '0;
    bus.c_nunit       = '0;
    bus.c_ublast      = 1'b0;
    bus.c_x1          = '0;
    bus.c_y1          = '0;
    tick();
    tick();

    // Reset state
    chk("rst_cst0", st(0), 0);
    chk("rst_cst1", st(1), 0);
    chk("rst_vc0", vc(0), 192);
    chk("rst_vc1", vc(1), 192);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_udf", bus.udf, 0);
    chk("rst_c", bus.c, 0);
    chk("rst_cfg_rdy", bus.cfg_rdy, 0);
    arst = 1'b0;
    tick();
    chk("run_vc0", vc(0), 192);

    // Memory: write then read, hold, same-address read-during-write, channel split
    bus.p_ch = 0; bus.p_waddr = 12'h005; bus.p = 8'hA5; bus.p_we_n = 1'b0;
    tick();
    bus.p_we_n = 1'b1;
    bus.c_ch = 0; bus.c_raddr = 12'h005; bus.c_re_n = 1'b0;
    tick();
    chk("mem_rd", bus.c, 8'hA5);
    bus.c_re_n = 1'b1;
    tick();
    chk("mem_hold", bus.c, 8'hA5);
    bus.p = 8'h5A; bus.p_we_n = 1'b0; bus.c_re_n = 1'b0;
    tick();
    chk("mem_rw_old", bus.c, 8'hA5);
    bus.p_we_n = 1'b1;
    tick();
    chk("mem_rw_new", bus.c, 8'h5A);
    bus.c_re_n = 1'b1;
    bus.p_ch = 1; bus.p = 8'h11; bus.p_we_n = 1'b0;
    tick();
    bus.p_we_n = 1'b1; bus.c_re_n = 1'b0;
    tick();
    chk("mem_ch0", bus.c, 8'h5A);
    bus.c_ch = 1;
    tick();
    chk("mem_ch1", bus.c, 8'h11);
    bus.c_re_n = 1'b1;

    // Interior block: pad 0, visible two cycles after the done pulse
    pulse_p(0, 16, 1, 63, 63);
    chk("int_lat1", st(0), 0);
    tick();
    chk("int_cst0", st(0), 16);
    chk("int_vc0", vc(0), 176);
    pulse_c(0, 16, 0, 63, 63);
    tick();
    chk("int_rel", st(0), 0);

    // Right-edge block on a 1928-wide picture: pad 224
    bus.pic_w = 13'd1928;
    pulse_p(0, 32, 1, 1927, 63);
    tick();
    chk("edge_cst0", st(0), 256);
    chk("edge_vc0", vc(0), 0);
    chk("edge_ovf", bus.ovf, 0);
    pulse_c(0, 32, 1, 1927, 63);
    tick();
    chk("edge_rel", st(0), 0);

    // Same-channel commit and release in one cycle: single net update
    pulse_p(1, 3, 0, 0, 0);
    tick();
    chk("sim_pre", st(1), 3);
    set_p(1, 10, 0, 0, 0);
    set_c(1, 4, 0, 0, 0);
    tick();
    bus.p_done = 1'b0; bus.c_done = 1'b0;
    chk("sim_lat1", st(1), 3);
    tick();
    chk("sim_cst1", st(1), 9);
    chk("sim_cst0", st(0), 0);
    chk("sim_udf", bus.udf, 0);
    pulse_c(1, 9, 0, 0, 0);
    tick();
    chk("sim_rel", st(1), 0);

    // Underflow on an empty channel
    pulse_c(0, 5, 0, 0, 0);
    tick();
    chk("udf_occ", st(0), 0);
    chk("udf_flag", bus.udf, 2'b01);

    // Overflow beyond CAP=256
    pulse_p(0, 200, 0, 0, 0);
    pulse_p(0, 100, 0, 0, 0);
    tick();
    chk("ovf_occ", st(0), 256);
    chk("ovf_flag", bus.ovf, 2'b01);
    chk("ovf_vc0", vc(0), 0);
    pulse_c(0, 256, 0, 0, 0);
    tick();
    chk("ovf_rel", st(0), 0);

    // Mode change blocked while occupied, accepted once empty, then DRAIN
    pulse_p(0, 3, 0, 0, 0);
    tick();
    bus.cfg_vld = 1'b1; bus.cfg_ub_log2 = 3'd5; bus.cfg_unit_log2 = 3'd2;
    #1;
    chk("cfg_busy", bus.cfg_rdy, 0);
    pulse_c(0, 3, 0, 0, 0);
    chk("cfg_inflight", bus.cfg_rdy, 0);
    tick();
    chk("cfg_rdy", bus.cfg_rdy, 1);
    tick();
    chk("cfg_drain", bus.cfg_rdy, 0);
    bus.cfg_vld = 1'b0;
    pulse_p(0, 7, 0, 0, 0);
    tick();
    tick();
    chk("drain_ignored", st(0), 0);

    // Edge block with UB=32: wi=8, hi=32, pad = 64-2*8 = 48
    pulse_p(0, 16, 1, 1927, 31);
    tick();
    chk("ub32_cst0", st(0), 64);
    chk("ub32_vc0", vc(0), 128);
    pulse_c(0, 16, 1, 1927, 31);
    tick();
    chk("ub32_rel", st(0), 0);

    // Illegal modes never handshake; a legal one does under the same conditions
    bus.cfg_vld = 1'b1; bus.cfg_ub_log2 = 3'd3; bus.cfg_unit_log2 = 3'd4;
    #1;
    chk("ill_unit_gt_ub", bus.cfg_rdy, 0);
    bus.cfg_ub_log2 = 3'd7; bus.cfg_unit_log2 = 3'd2;
    #1;
    chk("ill_ub_high", bus.cfg_rdy, 0);
    bus.cfg_ub_log2 = 3'd1; bus.cfg_unit_log2 = 3'd1;
    #1;
    chk("ill_low", bus.cfg_rdy, 0);
    bus.cfg_ub_log2 = 3'd6; bus.cfg_unit_log2 = 3'd2;
    #1;
    chk("cfg_legal", bus.cfg_rdy, 1);
    tick();
    bus.cfg_vld = 1'b0;
    tick();

    // Synchronous clear, including a commit issued in the clr cycle
    pulse_p(1, 5, 0, 0, 0);
    tick();
    chk("pre_clr", st(1), 5);
    set_p(1, 4, 0, 0, 0);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0; bus.p_done = 1'b0;
    chk("clr_cst1", st(1), 0);
    chk("clr_ovf", bus.ovf, 0);
    chk("clr_udf", bus.udf, 0);
    chk("clr_c", bus.c, 0);
    chk("clr_vc1", vc(1), 192);
    tick();
    tick();
    chk("clr_inflight", st(1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
